// File: rtl/floor_request_queue.sv
// Ordered queue of pending floor requests; head floor registered on pos0Mem, 1-cycle latency to head/status.
// Backpressure: requests arriving while full (and no same-cycle pop) are dropped and reported on req_drop.
// Optional duplicate filtering is built when REQ_DEDUP_EN is defined.
module floor_request_queue #(
    parameter int DEPTH   = 4,
    parameter int FLOOR_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic [FLOOR_W-1:0]           req_floor,
    input  logic                         deletePos0,
    output logic [FLOOR_W-1:0]           pos0Mem,
    output logic                         queue_empty,
    output logic                         queue_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         req_ack,
    output logic                         req_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLOOR_W-1:0] memQ [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtrNext;
    logic [PTR_W-1:0]   wrPtrNext;
    logic [CNT_W-1:0]   countNext;
    logic [FLOOR_W-1:0] headNext;
    logic               pop;
    logic               push;
    logic               dup;

`ifdef REQ_DEDUP_EN
    logic [DEPTH-1:0] validQ;

    // The head counts as pending even when it is retired this cycle: the car is already there.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (validQ[i] && (memQ[i] == req_floor)) begin
                dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ <= '0;
        end else begin
            if (pop) begin
                validQ[rdPtr] <= 1'b0;
            end
            if (push) begin
                validQ[wrPtr] <= 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        pop       = deletePos0 & ~queue_empty;
        push      = req_valid & ~dup & (~queue_full | pop);
        rdPtrNext = rdPtr + PTR_W'(pop);
        wrPtrNext = wrPtr + PTR_W'(push);
        countNext = count + CNT_W'(push) - CNT_W'(pop);
        headNext  = pos0Mem;
        // A push landing exactly at the new read pointer means the queue was otherwise empty.
        if (countNext != '0) begin
            if (push && (wrPtr == rdPtrNext)) begin
                headNext = req_floor;
            end else begin
                headNext = memQ[rdPtrNext];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            pos0Mem     <= '0;
            queue_empty <= 1'b1;
            queue_full  <= 1'b0;
            req_ack     <= 1'b0;
            req_drop    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                memQ[i] <= '0;
            end
        end else begin
            if (push) begin
                memQ[wrPtr] <= req_floor;
            end
            rdPtr       <= rdPtrNext;
            wrPtr       <= wrPtrNext;
            count       <= countNext;
            pos0Mem     <= headNext;
            queue_empty <= (countNext == '0);
            queue_full  <= (countNext == CNT_W'(DEPTH));
            req_ack     <= push;
            req_drop    <= req_valid & ~push;
        end
    end

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: directed vector table, wrap-around sequence, then random run vs a queue model.
module tb_floor_request_queue;

    localparam int DEPTH   = 4;
    localparam int FLOOR_W = 2;
`ifdef REQ_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic [FLOOR_W-1:0] req_floor = '0;
    logic               deletePos0 = 1'b0;
    logic [FLOOR_W-1:0] pos0Mem;
    logic               queue_empty;
    logic               queue_full;
    logic [2:0]         count;
    logic               req_ack;
    logic               req_drop;

    int tests = 0;
    int fails = 0;

    floor_request_queue #(.DEPTH(DEPTH), .FLOOR_W(FLOOR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .deletePos0 (deletePos0),
        .pos0Mem    (pos0Mem),
        .queue_empty(queue_empty),
        .queue_full (queue_full),
        .count      (count),
        .req_ack    (req_ack),
        .req_drop   (req_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       rv;
        logic [1:0] fl;
        logic       del;
        int         cnt;
        int         pos;
        logic       ack;
        logic       drop;
        logic       empty;
        logic       full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rn, logic rv, int fl, logic del, int cnt, int pos,
                                logic ack, logic drop, logic empty, logic full);
        vec_t v;
        v.rn = rn; v.rv = rv; v.fl = 2'(fl); v.del = del;
        v.cnt = cnt; v.pos = pos; v.ack = ack; v.drop = drop; v.empty = empty; v.full = full;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive(logic rn, logic rv, logic [1:0] fl, logic del);
        rst_n = rn; req_valid = rv; req_floor = fl; deletePos0 = del;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAll(string tag, int cnt, int pos, logic ack, logic drop, logic empty, logic full);
        check({tag, ".count"}, int'(count), cnt);
        check({tag, ".pos0Mem"}, int'(pos0Mem), pos);
        check({tag, ".req_ack"}, int'(req_ack), int'(ack));
        check({tag, ".req_drop"}, int'(req_drop), int'(drop));
        check({tag, ".empty"}, int'(queue_empty), int'(empty));
        check({tag, ".full"}, int'(queue_full), int'(full));
    endtask

    int         mq[$];
    int         mPos;
    logic       mPop, mPush, mDup, eAck, eDrop;
    logic       rn, rv, del;
    logic [1:0] fl;

    initial begin
        // rn rv fl del | cnt pos ack drop empty full
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 2, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 0, 3, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 0, 4, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 4, 0, 0, 1, 0, 1));
        // Full, head 0 retired while floor 0 is requested again.
        vecs.push_back(mk(1, 1, 0, 1, DEDUP ? 3 : 4, 1, !DEDUP, DEDUP, 0, !DEDUP));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 3, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 0, DEDUP ? 1 : 2, 3, !DEDUP, DEDUP, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, DEDUP ? 0 : 1, 3, 0, 0, DEDUP, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].rv, vecs[i].fl, vecs[i].del);
            checkAll($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pos, vecs[i].ack,
                     vecs[i].drop, vecs[i].empty, vecs[i].full);
        end

        // Alternating push/pop walks both pointers around the ring several times.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 2'(i % 4), 1'b0);
            checkAll($sformatf("wrapPush%0d", i), 1, i % 4, 1, 0, 0, 0);
            drive(1'b1, 1'b0, 2'd0, 1'b1);
            checkAll($sformatf("wrapPop%0d", i), 0, i % 4, 0, 0, 1, 0);
        end

        mq.delete();
        mPos = 0;
        for (int c = 0; c < 2000; c++) begin
            rn  = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            rv  = ($urandom_range(0, 1) == 1);
            fl  = 2'($urandom_range(0, 3));
            del = ($urandom_range(0, 9) < 4);
            if (!rn) begin
                mq.delete();
                mPos  = 0;
                eAck  = 1'b0;
                eDrop = 1'b0;
            end else begin
                mPop = del && (mq.size() > 0);
                mDup = 1'b0;
`ifdef REQ_DEDUP_EN
                foreach (mq[k]) if (mq[k] == int'(fl)) mDup = 1'b1;
`endif
                mPush = rv && !mDup && ((mq.size() < DEPTH) || mPop);
                if (mPop) void'(mq.pop_front());
                if (mPush) mq.push_back(int'(fl));
                if (mq.size() > 0) mPos = mq[0];
                eAck  = mPush;
                eDrop = rv && !mPush;
            end
            drive(rn, rv, fl, del);
            checkAll($sformatf("rnd%0d", c), mq.size(), mPos, eAck, eDrop,
                     mq.size() == 0, mq.size() == DEPTH);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
